// File: rtl/bit_packer_pkg.sv
// Shared definitions for the variable-length bit packer: default widths,
// FSM state encoding and counter-width helper.
package bit_packer_pkg;

    localparam int DEF_IN_W  = 64;
    localparam int DEF_OUT_W = 64;

    typedef logic [0:0] state_t;

    localparam state_t ST_RUN   = 1'b0;
    localparam state_t ST_FLUSH = 1'b1;

    // Bits needed to hold a count in the range 0..max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bit_packer_oreg.sv
// Single-entry output register for the bit packer: holds a packed word with
// its bit count and last flag until the downstream side accepts it.
module bit_packer_oreg
    import bit_packer_pkg::*;
#(
    parameter int W  = DEF_OUT_W,
    parameter int BW = cnt_width(DEF_OUT_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  ld_data,
    input  logic [BW-1:0] ld_bits,
    input  logic          ld_last,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [BW-1:0] out_bits,
    output logic          out_last
);

    logic          valid_q, valid_d;
    logic [W-1:0]  data_q, data_d;
    logic [BW-1:0] bits_q, bits_d;
    logic          last_q, last_d;

    // The caller only asserts load when the slot is empty or draining this
    // cycle, so a load always wins over the clear from a handshake.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        bits_d  = bits_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = ld_data;
            bits_d  = ld_bits;
            last_d  = ld_last;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            bits_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            bits_q  <= bits_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_bits  = bits_q;
    assign out_last  = last_q;

endmodule

// File: rtl/bit_packer.sv
// Variable-length bit packer: concatenates 1..IN_W-bit fragments LSB-first
// into OUT_W-bit words and flushes a zero-padded tail word at message end.
module bit_packer
    import bit_packer_pkg::*;
#(
    parameter int  IN_W  = DEF_IN_W,
    parameter int  OUT_W = DEF_OUT_W,
    localparam int IB_W  = cnt_width(IN_W),
    localparam int OB_W  = cnt_width(OUT_W),
    localparam int ACC_W = IN_W + OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic [IB_W-1:0]  in_bits,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [OB_W-1:0]  out_bits,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    localparam int              FW      = cnt_width(ACC_W);
    localparam logic [FW-1:0]   OUT_W_F = FW'(OUT_W);
    localparam logic [IB_W-1:0] IN_W_B  = IB_W'(IN_W);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [FW-1:0]    fill_q, fill_d;
    state_t           state_q, state_d;
    logic             err_q, err_d;

    logic             fill_ge;
    logic             has_word;
    logic             emit;
    logic             emit_last;
    logic [FW-1:0]    emit_bits;
    logic             in_ready_c;
    logic             accept;
    logic             bits_legal;
    logic [ACC_W-1:0] acc_post;
    logic [FW-1:0]    fill_post;
    logic [ACC_W-1:0] mask;
    logic [ACC_W-1:0] frag;

    always_comb begin
        fill_ge    = (fill_q >= OUT_W_F);
        has_word   = fill_ge || ((state_q == ST_FLUSH) && (fill_q != '0));
        emit       = has_word && (!out_valid || out_ready);
        emit_bits  = fill_ge ? OUT_W_F : fill_q;
        emit_last  = (state_q == ST_FLUSH) && (fill_q <= OUT_W_F);
        in_ready_c = (state_q == ST_RUN) && (!fill_ge || emit);
        accept     = in_valid && in_ready_c;
        bits_legal = (in_bits != '0) && (in_bits <= IN_W_B);

        // Emission is applied first so an accepted fragment lands right
        // after whatever bits remain once the outgoing word is removed.
        acc_post   = emit ? (acc_q >> OUT_W) : acc_q;
        fill_post  = emit ? (fill_q - emit_bits) : fill_q;
        mask       = ~({ACC_W{1'b1}} << in_bits);
        frag       = ACC_W'(in_data) & mask;

        acc_d  = acc_post;
        fill_d = fill_post;
        if (accept && bits_legal) begin
            acc_d  = acc_post | (frag << fill_post);
            fill_d = fill_post + FW'(in_bits);
        end

        err_d = accept && !bits_legal;

        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (accept && in_last) begin
                state_d = ST_FLUSH;
            end
        end else if ((fill_q == '0) || (emit && emit_last)) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            fill_q  <= '0;
            state_q <= ST_RUN;
            err_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    bit_packer_oreg #(
        .W  (OUT_W),
        .BW (OB_W)
    ) u_oreg (
        .clk       (clk),
        .rst       (rst),
        .load      (emit),
        .ld_data   (acc_q[OUT_W-1:0]),
        .ld_bits   (OB_W'(emit_bits)),
        .ld_last   (emit_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_bits  (out_bits),
        .out_last  (out_last)
    );

    assign in_ready = in_ready_c;
    assign err      = err_q;

endmodule

// File: tb/tb_bit_packer.sv
// Directed bench for bit_packer (8/16 instance) plus a 64/64 instance
// checked against a bit-queue reference model.
module tb_bit_packer;

    typedef struct {
        logic [15:0] d;
        logic [4:0]  b;
        logic        l;
    } w16_t;

    typedef struct {
        logic [63:0] d;
        logic [6:0]  b;
        logic        l;
    } w64_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [7:0]  in_data;
    logic [3:0]  in_bits;
    logic        in_valid, in_last, in_ready;
    logic [15:0] out_data;
    logic [4:0]  out_bits;
    logic        out_last, out_valid, out_ready, err;

    logic [63:0] r_in_data;
    logic [6:0]  r_in_bits;
    logic        r_in_valid, r_in_last, r_in_ready;
    logic [63:0] r_out_data;
    logic [6:0]  r_out_bits;
    logic        r_out_last, r_out_valid, r_out_ready, r_err;

    int n_vec = 0;
    int n_err = 0;
    int err_cnt = 0;
    int r_err_cnt = 0;
    w16_t words[$];
    w64_t r_words[$];

    always #5 clk = ~clk;

    bit_packer #(.IN_W(8), .OUT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_bits(in_bits), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_bits(out_bits), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    bit_packer #(.IN_W(64), .OUT_W(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_data(r_in_data), .in_bits(r_in_bits), .in_valid(r_in_valid),
        .in_last(r_in_last), .in_ready(r_in_ready),
        .out_data(r_out_data), .out_bits(r_out_bits), .out_last(r_out_last),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .err(r_err)
    );

    // Output words are recorded at the negedge preceding their handshake edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            words.push_back('{out_data, out_bits, out_last});
        if (!rst && err)
            err_cnt++;
        if (!rst && r_out_valid && r_out_ready)
            r_words.push_back('{r_out_data, r_out_bits, r_out_last});
        if (!rst && r_err)
            r_err_cnt++;
    end

    task automatic send(input logic [7:0] d, input logic [3:0] b, input logic l);
        logic done = 1'b0;
        in_data = d; in_bits = b; in_last = l; in_valid = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready=0 for 100 cycles, required 1 (data %h bits %0d)", d, b);
        end
    endtask

    task automatic wait_words(input int target, input string name);
        for (int c = 0; c < 100 && words.size() < target; c++) begin
            @(posedge clk); #2;
        end
        if (words.size() < target) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: got %0d words, required %0d", name, words.size(), target);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_word(input int idx, input logic [15:0] d, input logic [4:0] b,
                              input logic l, input string name);
        if (words.size() > idx) begin
            n_vec++;
            if (words[idx].d !== d || words[idx].b !== b || words[idx].l !== l) begin
                n_err++;
                $display("FAIL %s: got data=%h bits=%0d last=%0b, required data=%h bits=%0d last=%0b",
                         name, words[idx].d, words[idx].b, words[idx].l, d, b, l);
            end
        end
    endtask

    task automatic test_reset();
        in_data = '0; in_bits = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        r_in_data = '0; r_in_bits = '0; r_in_valid = 1'b0; r_in_last = 1'b0; r_out_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_vec++; if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_out_data: got %h, required 0000", out_data); end
        n_vec++; if (out_bits !== 5'd0) begin n_err++; $display("FAIL reset_out_bits: got %0d, required 0", out_bits); end
        n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b, required 0", out_last); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b, required 0", err); end
        n_vec++; if (r_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_r_out_valid: got %b, required 0", r_out_valid); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_word();
        int b = words.size();
        send(8'hAB, 4'd8, 1'b0);
        send(8'hCD, 4'd8, 1'b0);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_k1: out_valid=%b, required 0", out_valid); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL latency_k2: out_valid=%b, required 1", out_valid); end
        @(posedge clk); #1;
        wait_words(b + 1, "full_word");
        check_word(b, 16'hCDAB, 5'd16, 1'b0, "full_word");
        idle(3);
    endtask

    task automatic test_mask_flush();
        int b = words.size();
        send(8'hFD, 4'd3, 1'b0);
        send(8'h13, 4'd5, 1'b0);
        send(8'h0E, 4'd4, 1'b1);
        wait_words(b + 1, "mask_flush");
        check_word(b, 16'h0E9D, 5'd12, 1'b1, "mask_flush");
        idle(3);
    endtask

    task automatic test_exact_flush();
        int b = words.size();
        send(8'h11, 4'd8, 1'b0);
        send(8'h22, 4'd8, 1'b1);
        wait_words(b + 1, "exact_flush");
        check_word(b, 16'h2211, 5'd16, 1'b1, "exact_flush");
        idle(8);
        n_vec++; if (words.size() !== b + 1) begin n_err++; $display("FAIL exact_flush_count: got %0d words, required %0d", words.size() - b, 1); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL exact_flush_idle: out_valid=%b, required 0", out_valid); end
    endtask

    task automatic test_backpressure();
        int   b = words.size();
        int   idx = 0;
        logic saw_stall = 1'b0;
        logic hs;
        for (int c = 0; c < 300 && idx < 12; c++) begin
            out_ready = (c >= 10);
            in_valid = 1'b1; in_data = 8'(8'h30 + idx); in_bits = 4'd8; in_last = (idx == 11);
            @(negedge clk);
            hs = in_ready;
            if (!in_ready) saw_stall = 1'b1;
            @(posedge clk); #1;
            if (hs) idx++;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        n_vec++; if (idx !== 12) begin n_err++; $display("FAIL backpressure_accept: got %0d fragments, required 12", idx); end
        n_vec++; if (saw_stall !== 1'b1) begin n_err++; $display("FAIL backpressure_stall: in_ready low seen=%b, required 1", saw_stall); end
        wait_words(b + 6, "backpressure");
        for (int j = 0; j < 6; j++)
            check_word(b + j, {8'(8'h31 + 2 * j), 8'(8'h30 + 2 * j)}, 5'd16, (j == 5), "backpressure_word");
        idle(5);
        n_vec++; if (words.size() !== b + 6) begin n_err++; $display("FAIL backpressure_count: got %0d words, required 6", words.size() - b); end
    endtask

    task automatic test_illegal();
        int b = words.size();
        int e = err_cnt;
        send(8'hFF, 4'd9, 1'b0);
        send(8'hFF, 4'd0, 1'b0);
        send(8'h34, 4'd8, 1'b0);
        send(8'h12, 4'd8, 1'b1);
        wait_words(b + 1, "illegal");
        check_word(b, 16'h1234, 5'd16, 1'b1, "illegal_stream");
        idle(2);
        n_vec++; if (err_cnt - e !== 2) begin n_err++; $display("FAIL illegal_err: got %0d pulses, required 2", err_cnt - e); end
        send(8'h55, 4'd0, 1'b1);
        idle(5);
        n_vec++; if (err_cnt - e !== 3) begin n_err++; $display("FAIL illegal_last_err: got %0d pulses, required 3", err_cnt - e); end
        n_vec++; if (words.size() !== b + 1) begin n_err++; $display("FAIL illegal_last_words: got %0d words, required 1", words.size() - b); end
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL illegal_last_run: in_ready=%b, required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int b;
        out_ready = 1'b0;
        send(8'h11, 4'd8, 1'b0);
        send(8'h22, 4'd8, 1'b0);
        send(8'hAB, 4'd8, 1'b0);
        send(8'h0C, 4'd4, 1'b0);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || out_data !== 16'h2211) begin
            n_err++; $display("FAIL reset_mid_held: valid=%b data=%h, required 1 2211", out_valid, out_data);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || out_data !== 16'h0 || out_bits !== 5'd0 || out_last !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_outputs: valid=%b data=%h bits=%0d last=%b, required 0 0000 0 0",
                              out_valid, out_data, out_bits, out_last);
        end
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        b = words.size();
        send(8'h78, 4'd8, 1'b0);
        send(8'h56, 4'd8, 1'b1);
        wait_words(b + 1, "reset_mid");
        check_word(b, 16'h5678, 5'd16, 1'b1, "reset_mid_word");
        idle(6);
        n_vec++; if (words.size() !== b + 1) begin n_err++; $display("FAIL reset_mid_count: got %0d words, required 1", words.size() - b); end
    endtask

    task automatic r_send(input logic [63:0] d, input int len, input logic l);
        logic done = 1'b0;
        r_in_data = d; r_in_bits = 7'(len); r_in_last = l; r_in_valid = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            r_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            done = r_in_ready;
            @(posedge clk); #1;
        end
        r_in_valid = 1'b0; r_in_last = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL r_send_timeout: in_ready=0 for 300 cycles, required 1 (bits %0d)", len);
        end
    endtask

    task automatic test_random_64();
        bit   mq[$];
        w64_t exp_q[$];
        int   b = r_words.size();
        int   e = r_err_cnt;
        for (int i = 0; i < 60; i++) begin
            int          len = $urandom_range(1, 64);
            logic [63:0] d = {$urandom(), $urandom()};
            logic        l = (i % 7 == 6) || (i == 59);
            r_send(d, len, l);
            for (int k = 0; k < len; k++) mq.push_back(d[k]);
            while (mq.size() >= 64 || (l && mq.size() > 0)) begin
                w64_t w;
                int   n = (mq.size() >= 64) ? 64 : mq.size();
                w.d = '0;
                for (int k = 0; k < n; k++) w.d[k] = mq.pop_front();
                w.b = 7'(n);
                w.l = l && (mq.size() == 0);
                exp_q.push_back(w);
            end
        end
        r_out_ready = 1'b1;
        for (int c = 0; c < 500 && r_words.size() < b + exp_q.size(); c++) begin
            @(posedge clk); #2;
        end
        idle(4);
        n_vec++; if (r_words.size() - b !== exp_q.size()) begin
            n_err++; $display("FAIL random64_count: got %0d words, required %0d", r_words.size() - b, exp_q.size());
        end
        for (int j = 0; j < exp_q.size() && b + j < r_words.size(); j++) begin
            n_vec++;
            if (r_words[b + j].d !== exp_q[j].d || r_words[b + j].b !== exp_q[j].b || r_words[b + j].l !== exp_q[j].l) begin
                n_err++;
                $display("FAIL random64_word%0d: got data=%h bits=%0d last=%0b, required data=%h bits=%0d last=%0b",
                         j, r_words[b + j].d, r_words[b + j].b, r_words[b + j].l, exp_q[j].d, exp_q[j].b, exp_q[j].l);
            end
        end
        n_vec++; if (r_err_cnt - e !== 0) begin n_err++; $display("FAIL random64_err: got %0d pulses, required 0", r_err_cnt - e); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_mask_flush();
        test_exact_flush();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random_64();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
